// File: rtl/mem_stage_if.sv
// Bus bundle for the memory stage: EX/MEM inputs, data-memory handshake,
// MEM/WB outputs and pipeline status. master = pipeline/memory side, slave = mem_stage.
interface mem_stage_if;
    logic        exmem_valid;
    logic [3:0]  exmem_op;
    logic [3:0]  exmem_rd;
    logic [15:0] exmem_ma;
    logic [15:0] exmem_ad;

    logic        dmem_req;
    logic        dmem_wr;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    logic        stall_n;
    logic        memwb_valid;
    logic [3:0]  memwb_op;
    logic [3:0]  memwb_rd;
    logic [15:0] memwb_md;
    logic [15:0] memwb_ad;
    logic        memwb_we;
    logic        hlt;
    logic        mem_err;

    modport master (
        output exmem_valid, exmem_op, exmem_rd, exmem_ma, exmem_ad,
        output dmem_ack, dmem_rdata,
        input  dmem_req, dmem_wr, dmem_addr, dmem_wdata,
        input  stall_n, memwb_valid, memwb_op, memwb_rd, memwb_md, memwb_ad, memwb_we,
        input  hlt, mem_err
    );

    modport slave (
        input  exmem_valid, exmem_op, exmem_rd, exmem_ma, exmem_ad,
        input  dmem_ack, dmem_rdata,
        output dmem_req, dmem_wr, dmem_addr, dmem_wdata,
        output stall_n, memwb_valid, memwb_op, memwb_rd, memwb_md, memwb_ad, memwb_we,
        output hlt, mem_err
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues LW/SW to a handshaked data memory, stalls
// upstream while an access is outstanding, and fills the MEM/WB register.
//
// state  | meaning
// IDLE   | no access outstanding; EX/MEM instruction handled this cycle
// BUSY   | dmem request outstanding; EX/MEM held until ack or timeout
// HALTED | HLT retired or memory timed out; left only by reset
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HALTED} state_e;

    state_e      state_q;
    logic [9:0]  cnt_q;
    logic        dmem_req_q;
    logic        dmem_wr_q;
    logic [15:0] dmem_addr_q;
    logic [15:0] dmem_wdata_q;
    logic        memwb_valid_q;
    logic [3:0]  memwb_op_q;
    logic [3:0]  memwb_rd_q;
    logic [15:0] memwb_md_q;
    logic [15:0] memwb_ad_q;
    logic        memwb_we_q;
    logic        hlt_q;
    logic        mem_err_q;

    logic        is_mem_d;
    logic        we_d;
    logic        stall_n_d;

    assign is_mem_d = (bus.exmem_op == OP_LW) || (bus.exmem_op == OP_SW);
    // Register-file write enable for the op currently in EX/MEM (valid applied at load)
    assign we_d = ((bus.exmem_op < 4'b1100) && (bus.exmem_op != OP_SW)) ||
                  (bus.exmem_op == 4'b1110);

    always_comb begin
        stall_n_d = 1'b1;
        case (state_q)
            S_IDLE:   stall_n_d = !(bus.exmem_valid && is_mem_d);
            S_BUSY:   stall_n_d = bus.dmem_ack;
            S_HALTED: stall_n_d = 1'b0;
            default:  stall_n_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            dmem_req_q    <= 1'b0;
            dmem_wr_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            memwb_valid_q <= 1'b0;
            memwb_op_q    <= '0;
            memwb_rd_q    <= '0;
            memwb_md_q    <= '0;
            memwb_ad_q    <= '0;
            memwb_we_q    <= 1'b0;
            hlt_q         <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            // MEM/WB takes a bubble unless an instruction retires this edge
            memwb_valid_q <= 1'b0;
            memwb_op_q    <= '0;
            memwb_rd_q    <= '0;
            memwb_md_q    <= '0;
            memwb_ad_q    <= '0;
            memwb_we_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.exmem_valid) begin
                        if (is_mem_d) begin
                            dmem_req_q   <= 1'b1;
                            dmem_wr_q    <= (bus.exmem_op == OP_SW);
                            dmem_addr_q  <= bus.exmem_ma;
                            dmem_wdata_q <= bus.exmem_ad;
                            cnt_q        <= '0;
                            state_q      <= S_BUSY;
                        end else begin
                            memwb_valid_q <= 1'b1;
                            memwb_op_q    <= bus.exmem_op;
                            memwb_rd_q    <= bus.exmem_rd;
                            memwb_ad_q    <= bus.exmem_ad;
                            memwb_we_q    <= we_d;
                            if (bus.exmem_op == OP_HLT) begin
                                hlt_q   <= 1'b1;
                                state_q <= S_HALTED;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    // EX/MEM is held while BUSY, so its fields still describe the access
                    if (bus.dmem_ack) begin
                        dmem_req_q    <= 1'b0;
                        memwb_valid_q <= 1'b1;
                        memwb_op_q    <= bus.exmem_op;
                        memwb_rd_q    <= bus.exmem_rd;
                        memwb_ad_q    <= bus.exmem_ma;
                        memwb_md_q    <= (bus.exmem_op == OP_LW) ? bus.dmem_rdata : 16'h0000;
                        memwb_we_q    <= we_d;
                        state_q       <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        dmem_req_q <= 1'b0;
                        mem_err_q  <= 1'b1;
                        hlt_q      <= 1'b1;
                        state_q    <= S_HALTED;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_HALTED: begin
                    dmem_req_q <= 1'b0;
                end
                default: begin
                    dmem_req_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall_n     = stall_n_d;
    assign bus.dmem_req    = dmem_req_q;
    assign bus.dmem_wr     = dmem_wr_q;
    assign bus.dmem_addr   = dmem_addr_q;
    assign bus.dmem_wdata  = dmem_wdata_q;
    assign bus.memwb_valid = memwb_valid_q;
    assign bus.memwb_op    = memwb_op_q;
    assign bus.memwb_rd    = memwb_rd_q;
    assign bus.memwb_md    = memwb_md_q;
    assign bus.memwb_ad    = memwb_ad_q;
    assign bus.memwb_we    = memwb_we_q;
    assign bus.hlt         = hlt_q;
    assign bus.mem_err     = mem_err_q;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage pipeline: consumes the EX/MEM pipeline register, performs loads and stores against a handshaked data memory, and produces the MEM/WB pipeline register plus write-back control. Stalls the upstream pipeline while a memory access is outstanding. Raises the processor `hlt` on a retired HLT and latches a sticky error on a memory timeout.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles before a memory error; range 1..1023.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `exmem_valid` in 1: EX/MEM holds a real instruction (0 = bubble).
- `exmem_op` in 4: opcode.
- `exmem_rd` in 4: destination register.
- `exmem_ma` in 16: memory address for LW/SW.
- `exmem_ad` in 16: store data for SW, or ALU result for non-memory ops.
- `dmem_req` out 1: memory request.
- `dmem_wr` out 1: 1 = write, 0 = read.
- `dmem_addr` out 16: memory address.
- `dmem_wdata` out 16: write data.
- `dmem_ack` in 1: memory completion, valid only while `dmem_req`=1.
- `dmem_rdata` in 16: read data, valid with `dmem_ack`.
- `stall_n` out 1: 0 = upstream holds EX/MEM and everything before it.
- `memwb_valid` out 1: MEM/WB holds a real instruction.
- `memwb_op` out 4, `memwb_rd` out 4: registered copies of the opcode and destination register.
- `memwb_md` out 16: load data.
- `memwb_ad` out 16: ALU result or address.
- `memwb_we` out 1: register-file write enable.
- `hlt` out 1: halt, sticky.
- `mem_err` out 1: memory timeout, sticky.

## Operation
- **Opcodes:**
  - LW = 4'b1000, SW = 4'b1001, HLT = 4'b1111.
  - `memwb_we` = valid & (op < 4'b1100 & op != SW | op == 4'b1110).
- **FSM states:** IDLE, BUSY, HALTED.
- **IDLE:**
  - Valid non-memory, non-HLT op: MEM/WB loads op, rd, ad; `memwb_md`=0; `stall_n`=1.
  - Valid LW/SW: `stall_n`=0 combinationally; MEM/WB loads a bubble (`memwb_valid`=0).
    - Next edge registers `dmem_req`=1, `dmem_wr` (1 for SW), `dmem_addr`=ma, `dmem_wdata`=ad; go to BUSY; clear the timeout counter.
  - Valid HLT: MEM/WB loads HLT, `memwb_we`=0, `hlt`=1; go to HALTED.
  - Bubble: MEM/WB loads a bubble.
- **BUSY:**
  - `dmem_req`, `dmem_wr`, `dmem_addr`, `dmem_wdata` held constant.
  - `stall_n` = `dmem_ack`, combinationally.
  - On `dmem_ack`:
    - `dmem_req` drops at the next edge.
    - MEM/WB loads op, rd, ad = ma, and `md` = `dmem_rdata` for LW (0 for SW).
    - Return to IDLE.
  - Without ack: counter increments and MEM/WB loads a bubble.
  - Counter reaches `TIMEOUT` without ack: drop `dmem_req`, set `mem_err`, set `hlt`, go to HALTED; that instruction does not retire.
- **HALTED:**
  - `stall_n`=0, `dmem_req`=0.
  - Inputs ignored; MEM/WB loads bubbles after the HLT retires.
  - Left only by reset.
- **Reset:**
  - Outputs: `dmem_req`=0, `dmem_wr`=0, `dmem_addr`=0, `dmem_wdata`=0, all `memwb_*`=0, `hlt`=0, `mem_err`=0.
  - State goes to IDLE and the counter to 0.
  - `stall_n` = 1 after reset, since it is combinational and IDLE has an empty input.
  - Reset in BUSY drops `dmem_req` at that edge; a late `dmem_ack` is then ignored.

## Timing
- Non-memory op: 1-cycle latency. Present in EX/MEM in cycle T, in MEM/WB after edge T.
- Memory op, minimum 2 cycles:
  - T: accept; `stall_n`=0.
  - T+1: `dmem_req`=1; `dmem_ack`=1; `stall_n`=1.
  - Result is in MEM/WB after edge T+1, and the next EX/MEM instruction is accepted at that edge.
- Each cycle of ack delay adds one stall cycle and one MEM/WB bubble.
- `dmem_ack` while `dmem_req`=0 is ignored.
- Back-to-back LW/SW: the second is accepted on the ack edge of the first and requested one cycle later. `dmem_req` is low for at least 1 cycle between requests.
- `stall_n` is combinational from state, `exmem_valid`, `exmem_op` and `dmem_ack`. No combinational path from the `dmem_*` inputs to the `dmem_*` outputs.
- `hlt` is asserted in the same cycle MEM/WB holds the HLT.

## Test plan
- **ALU pass-through:** op=0000, rd=3, ad=0x1234, valid=1 → next cycle `memwb_valid`=1, `memwb_rd`=3, `memwb_ad`=0x1234, `memwb_we`=1, `stall_n` stays 1.
- **LW with 0-wait ack:**
  - Stimulus: LW, ma=0x0040, rd=5; memory acks the first request cycle with 0xBEEF.
  - Response: `dmem_req` high exactly 1 cycle, `dmem_wr`=0; `stall_n` low for 1 cycle; MEM/WB has `md`=0xBEEF, `we`=1, rd=5.
- **SW with 3-cycle ack delay:**
  - Stimulus: SW, ma=0x0010, ad=0x00AA.
  - Response: `dmem_addr`/`dmem_wdata`/`dmem_wr`=1 stable for 4 cycles; 3 MEM/WB bubbles; `memwb_we`=0 on retire.
- **Back-to-back LW, LW, then ALU op:** two distinct requests with `dmem_req` low between them; no instruction dropped or duplicated, checked by the retire order in MEM/WB.
- **HLT:** HLT follows an ALU op → `hlt`=1 one cycle after the ALU op retires; `stall_n`=0 permanently; later valid inputs produce no `dmem_req`.
- **Timeout and reset mid-op:**
  - TIMEOUT=4, LW never acked → `mem_err`=1 and `hlt`=1 after 4 BUSY cycles, `dmem_req`=0.
  - Separately, assert `rst_n`=0 while BUSY → `dmem_req`=0 after that edge, all outputs at their reset values.
